soc_bus_fabric: RTL and testbench

- Parametrised memory-mapped interconnect between the FemtoRV32 bus and N peripheral slaves.
- Replaces the fixed 7-way chip-select decoder and combinational read mux in the SoC top.
- Decodes address pages to one-hot selects and registers the selected slave at strobe time, so read data is steered correctly while the slave is busy.
- Returns a fixed error word for unmapped accesses, aborts stalled slaves after a timeout, and records the first failing access in sticky error status.

---
 rtl/soc_bus_fabric.sv | 113 +++++++++++
 tb/tb_soc_bus_fabric.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: page-decoded interconnect between the FemtoRV32 bus and N_SLAVES peripherals.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   mem_addr/mem_rstrb/mem_wmask    CPU request (read strobe pulse, byte write mask)
//   mem_rdata/mem_rbusy/mem_wbusy   CPU response and stalls
//   s_cs/s_rd/s_wmask               per-slave select, read strobe, gated write mask
//   s_rdata/s_rbusy/s_wbusy         per-slave read data and stalls
//   err_clr                         clears the sticky error status
//   err_flag/err_cause/err_addr     sticky error, cause (01 unmapped, 10 timeout), first failing address
module soc_bus_fabric #(
    parameter int                     N_SLAVES    = 8,
    parameter logic [N_SLAVES*16-1:0] SLAVE_PAGES = {16'h0001, 16'h0044, 16'h0043, 16'h0042,
                                                     16'h0041, 16'h0040, 16'h0010, 16'h0000},
    parameter int                     TIMEOUT     = 255,
    parameter logic [31:0]            ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [31:0]             mem_addr,
    input  logic                    mem_rstrb,
    input  logic [3:0]              mem_wmask,
    output logic [31:0]             mem_rdata,
    output logic                    mem_rbusy,
    output logic                    mem_wbusy,
    output logic [N_SLAVES-1:0]     s_cs,
    output logic [N_SLAVES-1:0]     s_rd,
    output logic [4*N_SLAVES-1:0]   s_wmask,
    input  logic [32*N_SLAVES-1:0]  s_rdata,
    input  logic [N_SLAVES-1:0]     s_rbusy,
    input  logic [N_SLAVES-1:0]     s_wbusy,
    input  logic                    err_clr,
    output logic                    err_flag,
    output logic [1:0]              err_cause,
    output logic [31:0]             err_addr
);
    localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ABORT} state_t;
    state_t        state;
    logic [IW-1:0] idx, sel_q;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic          sel_vld_q, rd_q, both_q, wr, mapped, start, busy, timeout, err_ev, unmapped;
    always_comb begin
        idx  = '0;
        s_cs = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--)
            if (mem_addr[31:16] == SLAVE_PAGES[i*16 +: 16]) idx = IW'(i);
        mapped = 1'b0;
        for (int i = 0; i < N_SLAVES; i++)
            mapped = mapped | (mem_addr[31:16] == SLAVE_PAGES[i*16 +: 16]);
        if (mapped) s_cs[idx] = 1'b1;
        for (int i = 0; i < N_SLAVES; i++)
            s_wmask[i*4 +: 4] = s_cs[i] ? mem_wmask : 4'b0000;
    end
    assign s_rd     = s_cs & {N_SLAVES{mem_rstrb}};
    assign wr       = |mem_wmask;
    assign start    = (state == IDLE) && (mem_rstrb || wr);
    assign unmapped = start && !mapped;
    assign busy     = (state == RD_WAIT) ? s_rbusy[sel_q] : s_wbusy[sel_q];
    // A wait is aborted once busy has been seen high for TIMEOUT consecutive cycles.
    assign timeout  = (TIMEOUT != 0) && busy && (cnt == CLAST);
    assign err_ev   = unmapped || ((state == RD_WAIT || state == WR_WAIT) && timeout);
    assign mem_rbusy = (state == RD_WAIT) && s_rbusy[sel_q];
    assign mem_wbusy = ((state == WR_WAIT) || (state == RD_WAIT && both_q)) && s_wbusy[sel_q];
    // rd_q keeps ERR_DATA on the bus after writes and aborted reads.
    assign mem_rdata = (sel_vld_q && rd_q) ? s_rdata[sel_q*32 +: 32] : ERR_DATA;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            rd_q      <= 1'b0;
            both_q    <= 1'b0;
            addr_q    <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            err_cause <= 2'b00;
            err_addr  <= '0;
        end else begin
            if (start) begin
                sel_q     <= idx;
                sel_vld_q <= mapped;
                rd_q      <= mem_rstrb;
                both_q    <= mem_rstrb && wr;
                addr_q    <= mem_addr;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && mapped) state <= mem_rstrb ? RD_WAIT : WR_WAIT;
                end
                RD_WAIT, WR_WAIT: begin
                    if (!busy) state <= IDLE;
                    else if (timeout) begin
                        state <= ABORT;
                        rd_q  <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
            err_flag <= err_ev || (err_flag && !err_clr);
            if (err_ev && (!err_flag || err_clr)) begin
                err_cause <= unmapped ? 2'b01 : 2'b10;
                err_addr  <= unmapped ? mem_addr : addr_q;
            end else if (err_clr) begin
                err_cause <= 2'b00;
                err_addr  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: scoreboard-driven bench for soc_bus_fabric (default build plus a TIMEOUT=4 build).
module tb_soc_bus_fabric;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic         mem_rstrb = 1'b0;
    logic [3:0]   mem_wmask = '0;
    logic [255:0] s_rdata = '0;
    logic [7:0]   s_rbusy = '0, s_wbusy = '0;
    logic         err_clr = 1'b0;
    logic [31:0]  rdata, eaddr, rdata_t, eaddr_t;
    logic         rbusy, wbusy, eflag, rbusy_t, wbusy_t, eflag_t;
    logic [7:0]   cs, rd, cs_t, rd_t;
    logic [31:0]  wm, wm_t;
    logic [1:0]   ecause, ecause_t;
    logic [31:0]  sb[$];
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    soc_bus_fabric dut (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_rdata(rdata), .mem_rbusy(rbusy), .mem_wbusy(wbusy), .s_cs(cs), .s_rd(rd), .s_wmask(wm),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr),
        .err_flag(eflag), .err_cause(ecause), .err_addr(eaddr)
    );

    soc_bus_fabric #(.TIMEOUT(4)) dut_t (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_rdata(rdata_t), .mem_rbusy(rbusy_t), .mem_wbusy(wbusy_t), .s_cs(cs_t), .s_rd(rd_t), .s_wmask(wm_t),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr),
        .err_flag(eflag_t), .err_cause(ecause_t), .err_addr(eaddr_t)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic [31:0] a_after, input int sl, input int busy,
                          input logic [31:0] exp, input logic [7:0] exp_rd, output int n);
        logic [31:0] e;
        @(negedge clk);
        mem_addr = a;
        mem_rstrb = 1'b1;
        if (busy > 0) s_rbusy[sl] = 1'b1;
        sb.push_back(exp);
        #1;
        tests++;
        if (rd !== exp_rd) begin fails++; $display("FAIL s_rd: got %b expected %b", rd, exp_rd); end
        @(negedge clk);
        mem_rstrb = 1'b0;
        mem_addr = a_after;
        n = 0;
        while (rbusy === 1'b1 && n < 300) begin
            n++;
            if (n == busy) s_rbusy[sl] = 1'b0;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests++;
        if (rdata !== e) begin fails++; $display("FAIL rd_data: got %h expected %h", rdata, e); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if (rdata !== 32'hDEAD_BEEF || rbusy !== 1'b0 || wbusy !== 1'b0)
            begin fails++; $display("FAIL reset_bus: got %h/%b/%b expected deadbeef/0/0", rdata, rbusy, wbusy); end
        tests++;
        if (eflag !== 1'b0 || ecause !== 2'b00 || eaddr !== 32'h0)
            begin fails++; $display("FAIL reset_err: got %b/%b/%h expected 0/00/0", eflag, ecause, eaddr); end
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL reset_hold: got %h expected deadbeef", rdata); end
    endtask

    task automatic test_read_fast;
        int n;
        s_rdata[32 +: 32] = 32'h1234_5678;
        rd_txn(32'h0010_0004, 32'h0010_0004, 1, 0, 32'h1234_5678, 8'b0000_0010, n);
        tests++;
        if (n != 0) begin fails++; $display("FAIL fast_busy: got %0d cycles expected 0", n); end
    endtask

    task automatic test_read_wait;
        int n;
        s_rdata[0 +: 32]  = 32'hCAFE_0000;
        s_rdata[64 +: 32] = 32'hBAD2_2222;
        rd_txn(32'h0000_0000, 32'h0040_0000, 0, 5, 32'hCAFE_0000, 8'b0000_0001, n);
        tests++;
        if (n != 5) begin fails++; $display("FAIL wait_busy: got %0d cycles expected 5", n); end
        tests++;
        if (cs !== 8'b0000_0100) begin fails++; $display("FAIL wait_cs: got %b expected 00000100", cs); end
    endtask

    task automatic test_unmapped;
        int n;
        rd_txn(32'h0050_0000, 32'h0050_0000, 0, 0, 32'hDEAD_BEEF, 8'b0, n);
        tests++;
        if (cs !== 8'b0 || n != 0) begin fails++; $display("FAIL unm_cs: got %b/%0d expected 0/0", cs, n); end
        tests++;
        if (eflag !== 1'b1 || ecause !== 2'b01 || eaddr !== 32'h0050_0000)
            begin fails++; $display("FAIL unm_err: got %b/%b/%h expected 1/01/00500000", eflag, ecause, eaddr); end
    endtask

    task automatic test_timeout;
        int n;
        logic [31:0] e;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        mem_addr = 32'h0041_0000;
        mem_rstrb = 1'b1;
        s_rbusy[3] = 1'b1;
        sb.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        mem_rstrb = 1'b0;
        n = 0;
        while (rbusy_t === 1'b1 && n < 50) begin n++; @(negedge clk); end
        tests++;
        if (n != 4) begin fails++; $display("FAIL to_busy: got %0d cycles expected 4", n); end
        e = sb.pop_front();
        tests++;
        if (rdata_t !== e) begin fails++; $display("FAIL to_data: got %h expected %h", rdata_t, e); end
        tests++;
        if (eflag_t !== 1'b1 || ecause_t !== 2'b10 || eaddr_t !== 32'h0041_0000)
            begin fails++; $display("FAIL to_err: got %b/%b/%h expected 1/10/00410000", eflag_t, ecause_t, eaddr_t); end
        s_rbusy[3] = 1'b0;
        @(negedge clk);
        mem_addr = 32'h0060_0000;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        tests++;
        if (eflag_t !== 1'b1 || ecause_t !== 2'b10 || eaddr_t !== 32'h0041_0000)
            begin fails++; $display("FAIL to_sticky: got %b/%b/%h expected 1/10/00410000", eflag_t, ecause_t, eaddr_t); end
        tests++;
        if (eaddr !== 32'h0060_0000) begin fails++; $display("FAIL to_main_err: got %h expected 00600000", eaddr); end
    endtask

    task automatic test_write;
        int n;
        @(negedge clk);
        mem_addr = 32'h0044_0000;
        mem_wmask = 4'b0011;
        s_wbusy[6] = 1'b1;
        #1;
        tests++;
        if (wm !== 32'h0300_0000) begin fails++; $display("FAIL wr_mask: got %h expected 03000000", wm); end
        @(negedge clk);
        mem_wmask = 4'b0000;
        n = 0;
        while (wbusy === 1'b1 && n < 300) begin
            n++;
            if (n == 2) s_wbusy[6] = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (n != 2) begin fails++; $display("FAIL wr_busy: got %0d cycles expected 2", n); end
        mem_addr = 32'h0070_0000;
        mem_wmask = 4'b1111;
        err_clr = 1'b1;
        #1;
        tests++;
        if (wm !== 32'h0) begin fails++; $display("FAIL wr_unm_mask: got %h expected 0", wm); end
        @(negedge clk);
        mem_wmask = 4'b0000;
        err_clr = 1'b0;
        tests++;
        if (eflag !== 1'b1 || ecause !== 2'b01 || eaddr !== 32'h0070_0000)
            begin fails++; $display("FAIL clr_new_err: got %b/%b/%h expected 1/01/00700000", eflag, ecause, eaddr); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (eflag !== 1'b0) begin fails++; $display("FAIL clr: got %b expected 0", eflag); end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        mem_addr = 32'h0010_0000;
        mem_rstrb = 1'b1;
        s_rbusy[1] = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        tests++;
        if (rbusy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", rbusy); end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (rbusy !== 1'b0) begin fails++; $display("FAIL mid_async: got %b expected 0", rbusy); end
        @(negedge clk);
        resetn = 1'b1;
        s_rbusy[1] = 1'b0;
        @(negedge clk);
        tests++;
        if (eflag !== 1'b0 || rdata !== 32'hDEAD_BEEF || rbusy !== 1'b0)
            begin fails++; $display("FAIL mid_after: got %b/%h/%b expected 0/deadbeef/0", eflag, rdata, rbusy); end
        s_rdata[7*32 +: 32] = 32'h7777_0007;
        rd_txn(32'h0001_0010, 32'h0001_0010, 7, 0, 32'h7777_0007, 8'b1000_0000, n);
    endtask

    initial begin
        test_reset;
        test_read_fast;
        test_read_wait;
        test_unmapped;
        test_timeout;
        test_write;
        test_reset_mid;
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_left: got %0d expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
